// File: rtl/seg7_time_monitor_pkg.sv
// clock_mon_pkg: segment codes, monitor states and BCD time arithmetic
package clock_mon_pkg;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  typedef enum logic {SYNC, TRACK} state_t;
  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;
  // two-digit BCD increment that wraps to zero after max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction
  // HH:MM:SS + 1 s, 23:59:59 wraps to 00:00:00
  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t n;
    n.ss = bcd_inc(t.ss, 8'h59);
    n.mm = t.ss == 8'h59 ? bcd_inc(t.mm, 8'h59) : t.mm;
    n.hh = (t.ss == 8'h59 && t.mm == 8'h59) ? bcd_inc(t.hh, 8'h23) : t.hh;
    return n;
  endfunction
endpackage

// File: rtl/seg7_time_monitor_seg7_to_bcd.sv
// seg7_to_bcd: one 7-segment pattern back to a BCD digit with a valid flag
module seg7_to_bcd
  import clock_mon_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       valid
);
  logic [6:0] p;
  assign p = ACTIVE_LOW ? ~seg : seg;
  // only the ten exact digit patterns are accepted
  always_comb begin
    digit = 4'd0;
    valid = 1'b1;
    case (p)
      SEG_0: digit = 4'd0;
      SEG_1: digit = 4'd1;
      SEG_2: digit = 4'd2;
      SEG_3: digit = 4'd3;
      SEG_4: digit = 4'd4;
      SEG_5: digit = 4'd5;
      SEG_6: digit = 4'd6;
      SEG_7: digit = 4'd7;
      SEG_8: digit = 4'd8;
      SEG_9: digit = 4'd9;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_time_monitor.sv
// seg7_time_monitor: decodes the six-digit display and checks it advances one second per tick
module seg7_time_monitor
  import clock_mon_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clk_1hz,
  input  logic             reset,
  input  logic [6:0]       sec_units_display,
  input  logic [6:0]       sec_tens_display,
  input  logic [6:0]       min_units_display,
  input  logic [6:0]       min_tens_display,
  input  logic [6:0]       hour_units_display,
  input  logic [6:0]       hour_tens_display,
  output logic [7:0]       hour_bcd,
  output logic [7:0]       min_bcd,
  output logic [7:0]       sec_bcd,
  output logic             time_valid,
  output logic             locked,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  logic [5:0][6:0] seg;
  logic [5:0][3:0] d;
  logic [5:0]      v;
  bcd_time_t       frame, ref_time, ref_n;
  state_t          state, state_n;
  logic [3:0]      good, good_n;
  logic            legal, locked_n, err;
  assign seg = {hour_tens_display, hour_units_display, min_tens_display,
                min_units_display, sec_tens_display, sec_units_display};
  for (genvar g = 0; g < 6; g++) begin : dig
    seg7_to_bcd #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (.seg(seg[g]), .digit(d[g]), .valid(v[g]));
  end
  assign frame = {d[5], d[4], d[3], d[2], d[1], d[0]};
  assign legal = &v && frame.hh <= 8'h23 && d[3] <= 4'd5 && d[1] <= 4'd5;
  // next tracking state: resync, count good steps, or flag an error
  always_comb begin
    state_n  = state;
    ref_n    = ref_time;
    good_n   = good;
    locked_n = locked;
    err      = 1'b0;
    if (state == SYNC) begin
      if (legal) begin
        state_n = TRACK;
        ref_n   = frame;
        good_n  = 4'd0;
      end
    end else if (!legal) begin
      err      = 1'b1;
      state_n  = SYNC;
      good_n   = 4'd0;
      locked_n = 1'b0;
    end else if (frame == time_inc(ref_time)) begin
      ref_n    = frame;
      good_n   = good == LC ? good : good + 4'd1;
      locked_n = good_n == LC;
    end else begin
      err      = 1'b1;
      ref_n    = frame;
      good_n   = 4'd0;
      locked_n = 1'b0;
    end
  end
  // all state and outputs register on the tick
  always_ff @(posedge clk_1hz) begin
    if (reset) begin
      state      <= SYNC;
      ref_time   <= '0;
      good       <= 4'd0;
      locked     <= 1'b0;
      step_err   <= 1'b0;
      err_count  <= '0;
      time_valid <= 1'b0;
      {hour_bcd, min_bcd, sec_bcd} <= '0;
    end else begin
      state      <= state_n;
      ref_time   <= ref_n;
      good       <= good_n;
      locked     <= locked_n;
      step_err   <= err;
      err_count  <= (err && !(&err_count)) ? err_count + 1'b1 : err_count;
      time_valid <= legal;
      if (legal) {hour_bcd, min_bcd, sec_bcd} <= frame;
    end
  end
endmodule

// File: tb/tb_seg7_time_monitor.sv
// tb_seg7_time_monitor: table vectors plus randomized frames against a seconds-of-day model
module tb_seg7_time_monitor;
  localparam logic [6:0] LUT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic clk_1hz = 1'b0;
  logic reset = 1'b0;
  logic [41:0] fr = '0;
  always #5 clk_1hz = ~clk_1hz;
  logic [7:0] a_hour, a_min, a_sec, a_err, b_hour, b_min, b_sec, c_hour, c_min, c_sec, c_err;
  logic [1:0] b_err;
  logic a_valid, a_locked, a_step, b_valid, b_locked, b_step, c_valid, c_locked, c_step;
  int checks = 0;
  int errors = 0;
  seg7_time_monitor dut_a (
    .clk_1hz(clk_1hz), .reset(reset),
    .sec_units_display(fr[6:0]), .sec_tens_display(fr[13:7]),
    .min_units_display(fr[20:14]), .min_tens_display(fr[27:21]),
    .hour_units_display(fr[34:28]), .hour_tens_display(fr[41:35]),
    .hour_bcd(a_hour), .min_bcd(a_min), .sec_bcd(a_sec), .time_valid(a_valid),
    .locked(a_locked), .step_err(a_step), .err_count(a_err)
  );
  seg7_time_monitor #(.ERR_W(2)) dut_b (
    .clk_1hz(clk_1hz), .reset(reset),
    .sec_units_display(fr[6:0]), .sec_tens_display(fr[13:7]),
    .min_units_display(fr[20:14]), .min_tens_display(fr[27:21]),
    .hour_units_display(fr[34:28]), .hour_tens_display(fr[41:35]),
    .hour_bcd(b_hour), .min_bcd(b_min), .sec_bcd(b_sec), .time_valid(b_valid),
    .locked(b_locked), .step_err(b_step), .err_count(b_err)
  );
  seg7_time_monitor #(.ACTIVE_LOW(1'b1)) dut_c (
    .clk_1hz(clk_1hz), .reset(reset),
    .sec_units_display(~fr[6:0]), .sec_tens_display(~fr[13:7]),
    .min_units_display(~fr[20:14]), .min_tens_display(~fr[27:21]),
    .hour_units_display(~fr[34:28]), .hour_tens_display(~fr[41:35]),
    .hour_bcd(c_hour), .min_bcd(c_min), .sec_bcd(c_sec), .time_valid(c_valid),
    .locked(c_locked), .step_err(c_step), .err_count(c_err)
  );
  typedef struct {
    logic        rst;
    logic [41:0] f;
    logic        v, s, l;
    int          e;
    logic [23:0] t;
  } vec_t;
  function automatic logic [41:0] enc(int h, int m, int s);
    return {LUT[h/10], LUT[h%10], LUT[m/10], LUT[m%10], LUT[s/10], LUT[s%10]};
  endfunction
  function automatic logic [41:0] enc_t(int t);
    return enc(t / 3600, (t / 60) % 60, t % 60);
  endfunction
  function automatic logic [23:0] to_bcd(int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h/10), 4'(h%10), 4'(m/10), 4'(m%10), 4'(s/10), 4'(s%10)};
  endfunction
  function automatic int dec(logic [41:0] f);
    int dg [6];
    int h, m, s;
    for (int i = 0; i < 6; i++) begin
      dg[i] = -1;
      for (int k = 0; k < 10; k++) if (f[i*7 +: 7] == LUT[k]) dg[i] = k;
      if (dg[i] < 0) return -1;
    end
    h = dg[5] * 10 + dg[4];
    m = dg[3] * 10 + dg[2];
    s = dg[1] * 10 + dg[0];
    if (h > 23 || m > 59 || s > 59) return -1;
    return h * 3600 + m * 60 + s;
  endfunction
  function automatic vec_t mk(logic r, logic [41:0] f, logic v, logic s, logic l, int e, logic [23:0] t);
    vec_t x;
    x.rst = r; x.f = f; x.v = v; x.s = s; x.l = l; x.e = e; x.t = t;
    return x;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic check_all(string tag, logic v, logic s, logic l, int e, logic [23:0] t);
    chk({tag, " a_valid"}, 32'(a_valid), 32'(v));
    chk({tag, " a_step"}, 32'(a_step), 32'(s));
    chk({tag, " a_locked"}, 32'(a_locked), 32'(l));
    chk({tag, " a_err"}, 32'(a_err), e > 255 ? 255 : e);
    chk({tag, " a_time"}, 32'({a_hour, a_min, a_sec}), 32'(t));
    chk({tag, " b_err"}, 32'(b_err), e > 3 ? 3 : e);
    chk({tag, " b_step"}, 32'(b_step), 32'(s));
    chk({tag, " c_valid"}, 32'(c_valid), 32'(v));
    chk({tag, " c_step"}, 32'(c_step), 32'(s));
    chk({tag, " c_locked"}, 32'(c_locked), 32'(l));
    chk({tag, " c_time"}, 32'({c_hour, c_min, c_sec}), 32'(t));
  endtask
  task automatic apply(logic r, logic [41:0] f);
    @(negedge clk_1hz);
    reset = r;
    fr = f;
    @(posedge clk_1hz);
    #1;
  endtask
  vec_t tab [$];
  int cur, pick, x, me, mt, mref, mgood;
  logic rr, mv, ms, ml, msync;
  logic [41:0] f;
  initial begin
    tab.push_back(mk(1, enc(0, 0, 0), 0, 0, 0, 0, 24'h000000));
    tab.push_back(mk(0, enc(12, 34, 56), 1, 0, 0, 0, 24'h123456));
    tab.push_back(mk(0, enc(12, 34, 57), 1, 0, 0, 0, 24'h123457));
    tab.push_back(mk(0, enc(12, 34, 58), 1, 0, 0, 0, 24'h123458));
    tab.push_back(mk(0, enc(12, 34, 59), 1, 0, 1, 0, 24'h123459));
    tab.push_back(mk(1, enc(12, 35, 0), 0, 0, 0, 0, 24'h000000));
    tab.push_back(mk(0, enc(23, 59, 58), 1, 0, 0, 0, 24'h235958));
    tab.push_back(mk(0, enc(23, 59, 59), 1, 0, 0, 0, 24'h235959));
    tab.push_back(mk(0, enc(0, 0, 0), 1, 0, 0, 0, 24'h000000));
    tab.push_back(mk(0, enc(0, 0, 1), 1, 0, 1, 0, 24'h000001));
    tab.push_back(mk(0, enc(10, 0, 0), 1, 1, 0, 1, 24'h100000));
    tab.push_back(mk(0, enc(10, 0, 2), 1, 1, 0, 2, 24'h100002));
    tab.push_back(mk(0, enc(10, 0, 3), 1, 0, 0, 2, 24'h100003));
    tab.push_back(mk(0, enc(10, 0, 4), 1, 0, 0, 2, 24'h100004));
    tab.push_back(mk(0, enc(10, 0, 5), 1, 0, 1, 2, 24'h100005));
    tab.push_back(mk(0, enc(10, 0, 6) & ~42'h7F, 0, 1, 0, 3, 24'h100005));
    tab.push_back(mk(0, enc(10, 0, 7), 1, 0, 0, 3, 24'h100007));
    tab.push_back(mk(0, enc(10, 0, 8), 1, 0, 0, 3, 24'h100008));
    tab.push_back(mk(0, enc(24, 0, 9), 0, 1, 0, 4, 24'h100008));
    tab.push_back(mk(0, enc(24, 0, 10), 0, 0, 0, 4, 24'h100008));
    tab.push_back(mk(0, enc(10, 0, 11), 1, 0, 0, 4, 24'h100011));
    tab.push_back(mk(0, enc(10, 0, 13), 1, 1, 0, 5, 24'h100013));
    tab.push_back(mk(0, enc(10, 0, 15), 1, 1, 0, 6, 24'h100015));
    tab.push_back(mk(0, enc(10, 0, 17), 1, 1, 0, 7, 24'h100017));
    tab.push_back(mk(1, enc(10, 0, 18), 0, 0, 0, 0, 24'h000000));
    tab.push_back(mk(0, enc(0, 0, 5), 1, 0, 0, 0, 24'h000005));
    tab.push_back(mk(0, enc(0, 0, 4), 1, 1, 0, 1, 24'h000004));
    tab.push_back(mk(0, enc(0, 0, 4), 1, 1, 0, 2, 24'h000004));
    for (int i = 0; i < tab.size(); i++) begin
      apply(tab[i].rst, tab[i].f);
      check_all($sformatf("vec%0d", i), tab[i].v, tab[i].s, tab[i].l, tab[i].e, tab[i].t);
    end
    cur = 86380;
    msync = 0; mv = 0; ms = 0; ml = 0; me = 0; mt = 0; mref = 0; mgood = 0;
    apply(1'b1, enc_t(cur));
    check_all("rnd_rst", 0, 0, 0, 0, 24'h0);
    for (int n = 0; n < 600; n++) begin
      pick = $urandom_range(0, 99);
      rr = 1'b0;
      if (pick < 70) cur = (cur + 1) % 86400;
      else if (pick < 78) cur = (cur + $urandom_range(2, 100)) % 86400;
      else if (pick < 86 && pick >= 82) cur = $urandom_range(86390, 86399);
      f = enc_t(cur);
      if (pick >= 86 && pick < 91) f[$urandom_range(0, 5)*7 +: 7] = 7'($urandom);
      else if (pick >= 91 && pick < 95) f = enc(24 + $urandom_range(0, 5), (cur / 60) % 60, cur % 60);
      else if (pick >= 95 && pick < 97) f[3*7 +: 7] = LUT[$urandom_range(6, 9)];
      else if (pick >= 97) rr = 1'b1;
      apply(rr, f);
      if (rr) begin
        msync = 0; mv = 0; ms = 0; ml = 0; me = 0; mt = 0; mref = 0; mgood = 0;
      end else begin
        x = dec(f);
        mv = x >= 0;
        ms = 0;
        if (x >= 0) mt = x;
        if (!msync) begin
          if (x >= 0) begin
            msync = 1; mref = x; mgood = 0;
          end
        end else if (x < 0) begin
          ms = 1; me++; msync = 0; mgood = 0; ml = 0;
        end else if (x == (mref + 1) % 86400) begin
          mref = x;
          mgood = mgood < 3 ? mgood + 1 : 3;
          ml = mgood == 3;
        end else begin
          ms = 1; me++; mref = x; mgood = 0; ml = 0;
        end
      end
      check_all($sformatf("rnd%0d", n), mv, ms, ml, me, to_bcd(mt));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
